// File: rtl/vote_collector.sv
// vote_collector: sequential front end for the 4-input voter.
// Opens a ballot on i_start, gathers one yes/no vote per voter (ids 0..3)
// over a valid/ready handshake, closes the ballot when all four voters have
// voted or after TIMEOUT idle cycles, and then holds ballot and result
// until i_ack.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        opens a new ballot (honoured only when idle)
//   i_vote_valid   vote present on i_vote_id / i_vote_val
//   i_vote_id      voter index, maps to ballot bit I[id]
//   i_vote_val     1 = yes, 0 = no
//   o_vote_ready   a vote is accepted this cycle
//   o_ballot       assembled ballot I[3:0]
//   o_result       O[3:1] = {pass, tie, fail}
//   o_ballot_valid ballot and result are final
//   i_ack          consumer took the ballot
//   o_busy         collector not idle
//   o_dup_err      one-cycle pulse after a repeat vote from the same voter
//   o_timed_out    ballot was closed by timeout (sticky until next start)
module vote_collector #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_vote_valid,
  input  logic [1:0] i_vote_id,
  input  logic       i_vote_val,
  output logic       o_vote_ready,
  output logic [3:0] o_ballot,
  output logic [2:0] o_result,
  output logic       o_ballot_valid,
  input  logic       i_ack,
  output logic       o_busy,
  output logic       o_dup_err,
  output logic       o_timed_out
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_ballot;
  logic [3:0]      r_mask;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_result;
  logic            r_dup;
  logic            r_timed_out;

  logic            w_full;
  logic            w_seen;
  logic            w_expire;

  assign w_full   = &r_mask;
  assign w_seen   = r_mask[i_vote_id];
  // Timer holds the number of idle cycles already elapsed; this idle cycle
  // would be the TIMEOUT-th one.
  assign w_expire = (r_timer == TW'(TIMEOUT - 1));

  function automatic logic [2:0] map_result(input logic [3:0] b);
    logic [2:0] yes;
    yes = {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
    if (yes >= 3'd3)      map_result = 3'b100;
    else if (yes == 3'd2) map_result = 3'b010;
    else                  map_result = 3'b001;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ballot    <= '0;
      r_mask      <= '0;
      r_timer     <= '0;
      r_result    <= '0;
      r_dup       <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_dup <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= COLLECT;
            r_ballot    <= '0;
            r_mask      <= '0;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
          end
        end
        COLLECT: begin
          // A complete mask closes the ballot one cycle after the last vote.
          // Any vote offered in that closing cycle is necessarily a repeat;
          // it is dropped silently so dup_err never fires in DONE.
          if (w_full) begin
            r_state  <= DONE;
            r_result <= map_result(r_ballot);
          end else if (i_vote_valid) begin
            // A vote beats an expiring timer.
            r_timer <= '0;
            if (w_seen) begin
              r_dup <= 1'b1;
            end else begin
              r_ballot[i_vote_id] <= i_vote_val;
              r_mask[i_vote_id]   <= 1'b1;
            end
          end else if (w_expire) begin
            // Missing voters stay 0 in the ballot, i.e. count as no.
            r_state     <= DONE;
            r_timed_out <= 1'b1;
            r_result    <= map_result(r_ballot);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DONE: begin
          if (i_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_vote_ready   = (r_state == COLLECT);
  assign o_ballot_valid = (r_state == DONE);
  assign o_busy         = (r_state != IDLE);
  assign o_ballot       = r_ballot;
  assign o_result       = r_result;
  assign o_dup_err      = r_dup;
  assign o_timed_out    = r_timed_out;

endmodule

// File: tb/tb_vote_collector.sv
module tb_vote_collector;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst, start, vote_valid, vote_val, ack;
  logic [1:0] vote_id;
  logic       vote_ready, ballot_valid, busy, dup_err, timed_out;
  logic [3:0] ballot;
  logic [2:0] result;

  int checks = 0;
  int failures = 0;

  vote_collector #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_vote_valid(vote_valid), .i_vote_id(vote_id), .i_vote_val(vote_val),
    .o_vote_ready(vote_ready), .o_ballot(ballot), .o_result(result),
    .o_ballot_valid(ballot_valid), .i_ack(ack), .o_busy(busy),
    .o_dup_err(dup_err), .o_timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting, 2 done. votes[i] = -1 until voter i votes.
  int         m_phase = 0;
  int         m_votes[4];
  int         m_idle = 0;
  logic [3:0] m_ballot = '0;
  logic [2:0] m_result = '0;
  logic       m_timed = 1'b0;
  logic       m_dup = 1'b0;

  function automatic logic [2:0] verdict(input logic [3:0] b);
    int yes = 0;
    for (int i = 0; i < 4; i++) if (b[i]) yes++;
    if (yes >= 3) return 3'b100;
    if (yes == 2) return 3'b010;
    return 3'b001;
  endfunction

  function automatic bit all_in();
    for (int i = 0; i < 4; i++) if (m_votes[i] < 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic dup_next;
    dup_next = 1'b0;
    if (rst) begin
      m_phase = 0; m_idle = 0; m_ballot = '0; m_result = '0; m_timed = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_idle = 0; m_ballot = '0; m_timed = 1'b0;
        for (int i = 0; i < 4; i++) m_votes[i] = -1;
      end
    end else if (m_phase == 1) begin
      if (all_in()) begin
        m_phase = 2; m_result = verdict(m_ballot);
      end else if (vote_valid) begin
        m_idle = 0;
        if (m_votes[vote_id] >= 0) dup_next = 1'b1;
        else begin
          m_votes[vote_id] = int'(vote_val);
          m_ballot[vote_id] = vote_val;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_phase = 2; m_timed = 1'b1; m_result = verdict(m_ballot);
        end
      end
    end else begin
      if (ack) m_phase = 0;
    end
    m_dup = dup_next;
  end

  // Single compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #2;
    chk("vote_ready",   {7'd0, vote_ready},   {7'd0, m_phase == 1});
    chk("busy",         {7'd0, busy},         {7'd0, m_phase != 0});
    chk("ballot_valid", {7'd0, ballot_valid}, {7'd0, m_phase == 2});
    chk("ballot",       {4'd0, ballot},       {4'd0, m_ballot});
    chk("dup_err",      {7'd0, dup_err},      {7'd0, m_dup});
    chk("timed_out",    {7'd0, timed_out},    {7'd0, m_timed});
    if (m_phase == 2) chk("result", {5'd0, result}, {5'd0, m_result});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vote(input int id, input logic v);
    vote_valid = 1'b1; vote_id = 2'(id); vote_val = v;
    cyc(1);
    vote_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; cyc(1); ack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (ballot_valid !== 1'b1 && n < 40) begin cyc(1); n++; end
    if (ballot_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s: ballot_valid never rose within 40 cycles", name);
    end
  endtask

  initial begin
    logic [3:0] b;
    rst = 1'b1; start = 1'b0; vote_valid = 1'b0; vote_id = 2'd0;
    vote_val = 1'b0; ack = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("reset_busy",  {7'd0, busy},        8'd0);
    chk("reset_ready", {7'd0, vote_ready},  8'd0);
    chk("reset_valid", {7'd0, ballot_valid},8'd0);
    chk("reset_ballot",{4'd0, ballot},      8'd0);
    chk("reset_timed", {7'd0, timed_out},   8'd0);

    // Reset mid-collection, then a stray vote in IDLE.
    pulse_start(); vote(0, 1'b1); vote(1, 1'b1);
    chk("mid_ballot_pre", {4'd0, ballot}, 8'h03);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midrst_busy",   {7'd0, busy},       8'd0);
    chk("midrst_ballot", {4'd0, ballot},     8'd0);
    chk("midrst_ready",  {7'd0, vote_ready}, 8'd0);
    vote(2, 1'b1);
    chk("idle_vote_ballot", {4'd0, ballot}, 8'd0);
    chk("idle_vote_busy",   {7'd0, busy},   8'd0);

    // Full ballot 1101, one-cycle close latency.
    pulse_start();
    vote(0, 1'b1); vote(1, 1'b0); vote(2, 1'b1); vote(3, 1'b1);
    chk("full_latency", {7'd0, ballot_valid}, 8'd0);
    cyc(1);
    chk("full_valid",  {7'd0, ballot_valid}, 8'd1);
    chk("full_ballot", {4'd0, ballot},       8'h0D);
    chk("full_result", {5'd0, result},       8'h04);
    pulse_start();                        // ignored in DONE
    chk("done_start_ignored", {7'd0, ballot_valid}, 8'd1);
    pulse_ack();
    chk("full_ack_idle", {7'd0, busy}, 8'd0);

    // Exhaustive sweep, votes in order id3..id0.
    for (int v = 0; v < 16; v++) begin
      b = 4'(v);
      pulse_start();
      for (int id = 3; id >= 0; id--) vote(id, b[id]);
      wait_valid("sweep");
      chk("sweep_ballot", {4'd0, ballot}, {4'd0, b});
      chk("sweep_timed",  {7'd0, timed_out}, 8'd0);
      pulse_ack();
    end

    // Duplicate vote, plus start during COLLECT.
    pulse_start();
    vote(2, 1'b1); vote(2, 1'b0);
    chk("dup_pulse",  {7'd0, dup_err},   8'd1);
    chk("dup_keep",   {7'd0, ballot[2]}, 8'd1);
    start = 1'b1; vote(0, 1'b0); start = 1'b0;
    chk("dup_one_cycle", {7'd0, dup_err}, 8'd0);
    vote(1, 1'b0); vote(3, 1'b0);
    cyc(1);
    chk("dup_ballot", {4'd0, ballot}, 8'h04);
    chk("dup_result", {5'd0, result}, 8'h01);
    pulse_ack();

    // Timeout after 16 idle cycles.
    pulse_start();
    vote(0, 1'b1); vote(1, 1'b1);
    cyc(TIMEOUT - 1);
    chk("to_not_yet", {7'd0, ballot_valid}, 8'd0);
    cyc(1);
    chk("to_valid",  {7'd0, ballot_valid}, 8'd1);
    chk("to_ballot", {4'd0, ballot},       8'h03);
    chk("to_result", {5'd0, result},       8'h02);
    chk("to_timed",  {7'd0, timed_out},    8'd1);
    start = 1'b1; ack = 1'b1; cyc(1); start = 1'b0; ack = 1'b0;
    chk("startack_idle", {7'd0, busy}, 8'd0);
    cyc(1);
    chk("startack_no_open", {7'd0, busy},      8'd0);
    chk("timed_sticky",     {7'd0, timed_out}, 8'd1);

    // Vote on the 16th idle cycle wins over the timeout.
    pulse_start();
    chk("start_clears_timed", {7'd0, timed_out}, 8'd0);
    vote(0, 1'b1); vote(1, 1'b1);
    cyc(TIMEOUT - 1);
    vote(2, 1'b0);
    chk("late_no_timeout", {7'd0, ballot_valid}, 8'd0);
    chk("late_timed",      {7'd0, timed_out},    8'd0);
    vote(3, 1'b1);
    cyc(1);
    chk("late_ballot", {4'd0, ballot}, 8'h0B);
    chk("late_result", {5'd0, result}, 8'h04);
    pulse_ack();

    // Votes in IDLE leave the held ballot alone.
    vote(2, 1'b1);
    chk("idle_hold_ballot", {4'd0, ballot}, 8'h0B);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
